// File: rtl/aurora_hls_pkg.sv
// Shared definitions for the Aurora HLS statistics block.
// Holds the default counter width, the healthy status value, the control
// FSM encoding and the index map of the live counter bank.
package aurora_hls_pkg;

    localparam int unsigned AURORA_CNT_WIDTH_DEFAULT = 32;
    localparam logic [12:0] AURORA_STATUS_OK_DEFAULT = 13'h11ff;

    // Control FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SNAP_WAIT = 2'd1;
    localparam logic [1:0] ST_CLEAR     = 2'd2;

    // Position of each counter in the live/shadow banks; FIFO channels follow
    // from IDX_FIFO_BASE upward.
    localparam int unsigned IDX_NOT_OK    = 0;
    localparam int unsigned IDX_LINK_DROP = 1;
    localparam int unsigned IDX_TX_WORD   = 2;
    localparam int unsigned IDX_TX_BYTE   = 3;
    localparam int unsigned IDX_TX_FRAME  = 4;
    localparam int unsigned IDX_RX_WORD   = 5;
    localparam int unsigned IDX_RX_BYTE   = 6;
    localparam int unsigned IDX_RX_FRAME  = 7;
    localparam int unsigned IDX_FIFO_BASE = 8;

endpackage

// File: rtl/aurora_hls_sat_counter.sv
// Saturating accumulator used for every statistics counter.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   clear_i        - synchronous clear (wins over enable)
//   en_i           - add inc_i this cycle
//   inc_i          - increment value
//   count_next_o   - value the counter takes at the next clock edge; the
//                    owner samples it to capture events still in flight
module aurora_hls_sat_counter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [INC_WIDTH-1:0] inc_i,
    output logic [WIDTH-1:0]     count_next_o
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [SUM_W-1:0] sum;

    // Add with one guard bit, then clamp: an overflowing add yields all-ones.
    always_comb begin
        sum     = {1'b0, count_q} + SUM_W'(inc_i);
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_next_o = count_d;

endmodule

// File: rtl/aurora_hls_stats.sv
// Aurora link / AXI-Stream statistics collector.
// Counts status faults, link drops, FIFO almost-full episodes and TX/RX
// words, bytes and frames in saturating live counters, and publishes them
// through shadow registers loaded by a snapshot command.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   aurora_status                  - Aurora core status vector
//   fifo_almost_full               - per-FIFO almost-full flags
//   tx_tvalid/tready/tlast/tkeep   - TX stream handshake and byte enables
//   rx_tvalid/tlast/tkeep          - RX stream (no backpressure)
//   clear, snapshot                - single-cycle command pulses
//   status_ok                      - registered "status is healthy" flag
//   snap_valid                     - shadows hold a snapshot
//   *_count, fifo_full_count       - shadow counter outputs
module aurora_hls_stats
    import aurora_hls_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned NUM_FIFOS  = 2,
    parameter int unsigned CNT_WIDTH  = AURORA_CNT_WIDTH_DEFAULT,
    parameter logic [12:0] STATUS_OK  = AURORA_STATUS_OK_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [12:0]                    aurora_status,
    input  logic [NUM_FIFOS-1:0]           fifo_almost_full,
    input  logic                           tx_tvalid,
    input  logic                           tx_tready,
    input  logic                           tx_tlast,
    input  logic [DATA_WIDTH/8-1:0]        tx_tkeep,
    input  logic                           rx_tvalid,
    input  logic                           rx_tlast,
    input  logic [DATA_WIDTH/8-1:0]        rx_tkeep,
    input  logic                           clear,
    input  logic                           snapshot,
    output logic                           status_ok,
    output logic                           snap_valid,
    output logic [CNT_WIDTH-1:0]           status_not_ok_count,
    output logic [CNT_WIDTH-1:0]           link_drop_count,
    output logic [CNT_WIDTH-1:0]           tx_word_count,
    output logic [CNT_WIDTH-1:0]           tx_byte_count,
    output logic [CNT_WIDTH-1:0]           tx_frame_count,
    output logic [CNT_WIDTH-1:0]           rx_word_count,
    output logic [CNT_WIDTH-1:0]           rx_byte_count,
    output logic [CNT_WIDTH-1:0]           rx_frame_count,
    output logic [NUM_FIFOS*CNT_WIDTH-1:0] fifo_full_count
);

    localparam int unsigned KEEP_W  = DATA_WIDTH / 8;
    localparam int unsigned POP_W   = $clog2(KEEP_W + 1);
    localparam int unsigned NUM_CNT = IDX_FIFO_BASE + NUM_FIFOS;

    logic [1:0]           state_q, state_d;
    logic                 clr_pend_q, clr_pend_d;
    logic                 status_ok_q, status_ok_d;
    logic [NUM_FIFOS-1:0] fifo_prev_q;
    logic [NUM_CNT-1:0]   ev_q, ev_d;
    logic [POP_W-1:0]     tx_pop_q, tx_pop_d;
    logic [POP_W-1:0]     rx_pop_q, rx_pop_d;
    logic                 tx_beat, rx_beat;
    logic                 in_clear;
    logic                 snap_valid_q;
    logic [POP_W-1:0]     cnt_inc  [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_next [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];

    assign in_clear    = (state_q == ST_CLEAR);
    assign status_ok_d = (aurora_status == STATUS_OK);
    assign tx_beat     = tx_tvalid && tx_tready;
    assign rx_beat     = rx_tvalid;

    // Control FSM. A clear arriving together with a snapshot is remembered
    // and executed right after SNAP_WAIT; all other commands outside IDLE
    // are dropped.
    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (snapshot) begin
                    state_d    = ST_SNAP_WAIT;
                    clr_pend_d = clear;
                end else if (clear) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_SNAP_WAIT: begin
                state_d    = clr_pend_q ? ST_CLEAR : ST_IDLE;
                clr_pend_d = 1'b0;
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Event capture stage: one registered event flag per counter plus the
    // byte popcounts. Events seen during CLEAR are discarded here.
    always_comb begin
        tx_pop_d = '0;
        rx_pop_d = '0;
        for (int unsigned b = 0; b < KEEP_W; b++) begin
            tx_pop_d = tx_pop_d + POP_W'(tx_tkeep[b]);
            rx_pop_d = rx_pop_d + POP_W'(rx_tkeep[b]);
        end
        if (!tx_beat) tx_pop_d = '0;
        if (!rx_beat) rx_pop_d = '0;

        ev_d                = '0;
        ev_d[IDX_NOT_OK]    = !status_ok_d;
        ev_d[IDX_LINK_DROP] = status_ok_q && !status_ok_d;
        ev_d[IDX_TX_WORD]   = tx_beat;
        ev_d[IDX_TX_BYTE]   = tx_beat;
        ev_d[IDX_TX_FRAME]  = tx_beat && tx_tlast;
        ev_d[IDX_RX_WORD]   = rx_beat;
        ev_d[IDX_RX_BYTE]   = rx_beat;
        ev_d[IDX_RX_FRAME]  = rx_beat && rx_tlast;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            ev_d[IDX_FIFO_BASE + i] = fifo_almost_full[i] && !fifo_prev_q[i];
        end

        if (in_clear) begin
            ev_d     = '0;
            tx_pop_d = '0;
            rx_pop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clr_pend_q  <= 1'b0;
            status_ok_q <= 1'b0;
            fifo_prev_q <= '1;
            ev_q        <= '0;
            tx_pop_q    <= '0;
            rx_pop_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_pend_q  <= clr_pend_d;
            status_ok_q <= status_ok_d;
            fifo_prev_q <= fifo_almost_full;
            ev_q        <= ev_d;
            tx_pop_q    <= tx_pop_d;
            rx_pop_q    <= rx_pop_d;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CNT; c++) begin
            cnt_inc[c] = POP_W'(1);
        end
        cnt_inc[IDX_TX_BYTE] = tx_pop_q;
        cnt_inc[IDX_RX_BYTE] = rx_pop_q;
    end

    for (genvar c = 0; c < NUM_CNT; c++) begin : g_cnt
        aurora_hls_sat_counter #(
            .WIDTH     (CNT_WIDTH),
            .INC_WIDTH (POP_W)
        ) u_cnt (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear_i      (in_clear),
            .en_i         (ev_q[c]),
            .inc_i        (cnt_inc[c]),
            .count_next_o (cnt_next[c])
        );
    end

    // Shadows sample the counters' next values at the end of SNAP_WAIT, so
    // the events captured in the snapshot cycle itself are included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CNT; c++) shadow_q[c] <= '0;
            snap_valid_q <= 1'b0;
        end else if (in_clear) begin
            for (int unsigned c = 0; c < NUM_CNT; c++) shadow_q[c] <= '0;
            snap_valid_q <= 1'b0;
        end else if (state_q == ST_SNAP_WAIT) begin
            for (int unsigned c = 0; c < NUM_CNT; c++) shadow_q[c] <= cnt_next[c];
            snap_valid_q <= 1'b1;
        end
    end

    always_comb begin
        fifo_full_count = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            fifo_full_count[i*CNT_WIDTH +: CNT_WIDTH] = shadow_q[IDX_FIFO_BASE + i];
        end
    end

    assign status_ok           = status_ok_q;
    assign snap_valid          = snap_valid_q;
    assign status_not_ok_count = shadow_q[IDX_NOT_OK];
    assign link_drop_count     = shadow_q[IDX_LINK_DROP];
    assign tx_word_count       = shadow_q[IDX_TX_WORD];
    assign tx_byte_count       = shadow_q[IDX_TX_BYTE];
    assign tx_frame_count      = shadow_q[IDX_TX_FRAME];
    assign rx_word_count       = shadow_q[IDX_RX_WORD];
    assign rx_byte_count       = shadow_q[IDX_RX_BYTE];
    assign rx_frame_count      = shadow_q[IDX_RX_FRAME];

endmodule

// File: tb/tb_aurora_hls_stats.sv
// Self-checking bench for aurora_hls_stats: directed scenarios plus random
// traffic compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_aurora_hls_stats;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned NF = 2;
    localparam int unsigned CW = 32;
    localparam int unsigned NC = 8 + NF;
    localparam logic [12:0] OKV = 13'h11ff;
    localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT signals
    logic [12:0]      aurora_status = OKV;
    logic [NF-1:0]    fifo_almost_full = '0;
    logic             tx_tvalid = 0, tx_tready = 0, tx_tlast = 0;
    logic [KW-1:0]    tx_tkeep = '0;
    logic             rx_tvalid = 0, rx_tlast = 0;
    logic [KW-1:0]    rx_tkeep = '0;
    logic             clear = 0, snapshot = 0;
    logic             status_ok, snap_valid;
    logic [CW-1:0]    status_not_ok_count, link_drop_count;
    logic [CW-1:0]    tx_word_count, tx_byte_count, tx_frame_count;
    logic [CW-1:0]    rx_word_count, rx_byte_count, rx_frame_count;
    logic [NF*CW-1:0] fifo_full_count;

    // 16-bit counter instance for saturation
    logic [12:0] s_status = OKV;
    logic [0:0]  s_ff = '0;
    logic        s_txv = 0, s_txr = 0, s_txl = 0;
    logic [7:0]  s_txk = '0;
    logic        s_rxv = 0, s_rxl = 0;
    logic [7:0]  s_rxk = '0;
    logic        s_clear = 0, s_snapshot = 0;
    logic        s_status_ok, s_snap_valid;
    logic [15:0] s_notok, s_drop, s_txw, s_txb, s_txf, s_rxw, s_rxb, s_rxf, s_ffc;

    aurora_hls_stats #(
        .DATA_WIDTH (DW),
        .NUM_FIFOS  (NF),
        .CNT_WIDTH  (CW),
        .STATUS_OK  (OKV)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .aurora_status       (aurora_status),
        .fifo_almost_full    (fifo_almost_full),
        .tx_tvalid           (tx_tvalid),
        .tx_tready           (tx_tready),
        .tx_tlast            (tx_tlast),
        .tx_tkeep            (tx_tkeep),
        .rx_tvalid           (rx_tvalid),
        .rx_tlast            (rx_tlast),
        .rx_tkeep            (rx_tkeep),
        .clear               (clear),
        .snapshot            (snapshot),
        .status_ok           (status_ok),
        .snap_valid          (snap_valid),
        .status_not_ok_count (status_not_ok_count),
        .link_drop_count     (link_drop_count),
        .tx_word_count       (tx_word_count),
        .tx_byte_count       (tx_byte_count),
        .tx_frame_count      (tx_frame_count),
        .rx_word_count       (rx_word_count),
        .rx_byte_count       (rx_byte_count),
        .rx_frame_count      (rx_frame_count),
        .fifo_full_count     (fifo_full_count)
    );

    aurora_hls_stats #(
        .DATA_WIDTH (64),
        .NUM_FIFOS  (1),
        .CNT_WIDTH  (16),
        .STATUS_OK  (OKV)
    ) dut16 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .aurora_status       (s_status),
        .fifo_almost_full    (s_ff),
        .tx_tvalid           (s_txv),
        .tx_tready           (s_txr),
        .tx_tlast            (s_txl),
        .tx_tkeep            (s_txk),
        .rx_tvalid           (s_rxv),
        .rx_tlast            (s_rxl),
        .rx_tkeep            (s_rxk),
        .clear               (s_clear),
        .snapshot            (s_snapshot),
        .status_ok           (s_status_ok),
        .snap_valid          (s_snap_valid),
        .status_not_ok_count (s_notok),
        .link_drop_count     (s_drop),
        .tx_word_count       (s_txw),
        .tx_byte_count       (s_txb),
        .tx_frame_count      (s_txf),
        .rx_word_count       (s_rxw),
        .rx_byte_count       (s_rxb),
        .rx_frame_count      (s_rxf),
        .fifo_full_count     (s_ffc)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // ---------------- reference model ----------------
    // m: live totals since last clear; e: what the outputs must show.
    longint unsigned m [NC];
    longint unsigned e [NC];
    longint unsigned snap_buf [NC];
    logic            e_valid;
    logic            m_sok;
    logic [NF-1:0]   m_prev;
    int              drop_left, busy_left, load_cnt, zero_cnt;

    function automatic longint unsigned sat(longint unsigned a, longint unsigned b);
        return (a + b > MAXV) ? MAXV : a + b;
    endfunction

    function automatic string nm(int unsigned i);
        case (i)
            0: return "status_not_ok_count";
            1: return "link_drop_count";
            2: return "tx_word_count";
            3: return "tx_byte_count";
            4: return "tx_frame_count";
            5: return "rx_word_count";
            6: return "rx_byte_count";
            7: return "rx_frame_count";
            default: return $sformatf("fifo_full_count[%0d]", i - 8);
        endcase
    endfunction

    function automatic logic [63:0] obs(int unsigned i);
        case (i)
            0: return 64'(status_not_ok_count);
            1: return 64'(link_drop_count);
            2: return 64'(tx_word_count);
            3: return 64'(tx_byte_count);
            4: return 64'(tx_frame_count);
            5: return 64'(rx_word_count);
            6: return 64'(rx_byte_count);
            7: return 64'(rx_frame_count);
            default: return 64'(fifo_full_count[(i-8)*CW +: CW]);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m[i] = 0; e[i] = 0; snap_buf[i] = 0;
        end
        e_valid = 0; m_sok = 0; m_prev = '1;
        drop_left = 0; busy_left = 0; load_cnt = 0; zero_cnt = 0;
    endtask

    // Advance one clock; the model consumes the cycle that just ended.
    task automatic step();
        longint unsigned ev [NC];
        bit idle, dropped, txb, rxb;
        @(posedge clk);
        txb = tx_tvalid && tx_tready;
        rxb = rx_tvalid;
        ev[0] = (aurora_status != OKV) ? 1 : 0;
        ev[1] = (m_sok && aurora_status != OKV) ? 1 : 0;
        ev[2] = txb ? 1 : 0;
        ev[3] = txb ? longint'($countones(tx_tkeep)) : 0;
        ev[4] = (txb && tx_tlast) ? 1 : 0;
        ev[5] = rxb ? 1 : 0;
        ev[6] = rxb ? longint'($countones(rx_tkeep)) : 0;
        ev[7] = (rxb && rx_tlast) ? 1 : 0;
        for (int i = 0; i < NF; i++) ev[8+i] = (fifo_almost_full[i] && !m_prev[i]) ? 1 : 0;
        m_sok  = (aurora_status == OKV);
        m_prev = fifo_almost_full;

        idle = (busy_left == 0);
        if (busy_left > 0) busy_left--;
        dropped = (drop_left > 0);
        if (drop_left > 0) drop_left--;
        if (load_cnt > 0) begin
            load_cnt--;
            if (load_cnt == 0) begin e = snap_buf; e_valid = 1; end
        end
        if (zero_cnt > 0) begin
            zero_cnt--;
            if (zero_cnt == 0) begin
                for (int i = 0; i < NC; i++) e[i] = 0;
                e_valid = 0;
            end
        end
        // a lone clear discards this cycle's and the next cycle's events
        if (idle && clear && !snapshot) begin
            dropped = 1; drop_left = 1; zero_cnt = 1; busy_left = 1;
        end
        if (!dropped) for (int i = 0; i < NC; i++) m[i] = sat(m[i], ev[i]);
        if (idle && clear && !snapshot) for (int i = 0; i < NC; i++) m[i] = 0;
        if (idle && snapshot) begin
            snap_buf = m; load_cnt = 1; busy_left = 1;
            if (clear) begin
                for (int i = 0; i < NC; i++) m[i] = 0;
                drop_left = 2; zero_cnt = 2; busy_left = 2;
            end
        end
        #1;
    endtask

    task automatic quiet();
        aurora_status = OKV;
        tx_tvalid = 0; tx_tready = 0; tx_tlast = 0; tx_tkeep = '0;
        rx_tvalid = 0; rx_tlast = 0; rx_tkeep = '0;
        clear = 0; snapshot = 0;
    endtask

    task automatic take_snapshot(input bit with_clear);
        snapshot = 1; clear = with_clear;
        step();
        snapshot = 0; clear = 0;
        step();
    endtask

    task automatic do_clear();
        clear = 1;
        step();
        clear = 0;
        step();
    endtask

    task automatic rand_traffic();
        logic [KW-1:0] k;
        aurora_status = ($urandom_range(0, 4) == 0) ? 13'($urandom) : OKV;
        fifo_almost_full = NF'($urandom);
        tx_tvalid = 1'($urandom); tx_tready = 1'($urandom); tx_tlast = 1'($urandom);
        for (int i = 0; i < KW; i++) k[i] = 1'($urandom);
        tx_tkeep = k;
        rx_tvalid = 1'($urandom); rx_tlast = 1'($urandom);
        for (int i = 0; i < KW; i++) k[i] = 1'($urandom);
        rx_tkeep = k;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        quiet();
        fifo_almost_full = 2'b01;   // ch0 already almost-full across reset release
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (obs(i) !== e[i]) begin
                errors++;
                $display("FAIL reset_%s actual=%0d required=%0d", nm(i), obs(i), e[i]);
            end
        end
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_snap_valid actual=%b required=0", snap_valid); end
        checks++;
        if (status_ok !== 1'b0) begin errors++; $display("FAIL reset_status_ok actual=%b required=0", status_ok); end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        // the first edge after release is handled by the model directly
        m_sok = (aurora_status == OKV);
        m_prev = fifo_almost_full;
    endtask

    task automatic test_fifo();
        logic [NF-1:0] seq [7];
        seq = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
        for (int i = 0; i < 7; i++) begin
            fifo_almost_full = seq[i];
            step();
        end
        take_snapshot(0);
        checks++;
        if (obs(9) !== 64'd2) begin errors++; $display("FAIL fifo_ch1 actual=%0d required=2", obs(9)); end
        checks++;
        if (obs(8) !== 64'd0) begin errors++; $display("FAIL fifo_ch0 actual=%0d required=0", obs(8)); end
        checks++;
        if (snap_valid !== 1'b1) begin errors++; $display("FAIL fifo_snap_valid actual=%b required=1", snap_valid); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (obs(i) !== e[i]) begin
                errors++;
                $display("FAIL fifo_model_%s actual=%0d required=%0d", nm(i), obs(i), e[i]);
            end
        end
    endtask

    task automatic test_status();
        do_clear();
        aurora_status = OKV;
        repeat (10) step();
        checks++;
        if (status_ok !== 1'b1) begin errors++; $display("FAIL status_ok_high actual=%b required=1", status_ok); end
        aurora_status = 13'h0000;
        repeat (5) step();
        checks++;
        if (status_ok !== 1'b0) begin errors++; $display("FAIL status_ok_low actual=%b required=0", status_ok); end
        aurora_status = OKV;
        take_snapshot(0);
        checks++;
        if (obs(0) !== 64'd5) begin errors++; $display("FAIL status_not_ok actual=%0d required=5", obs(0)); end
        checks++;
        if (obs(1) !== 64'd1) begin errors++; $display("FAIL link_drop actual=%0d required=1", obs(1)); end
    endtask

    task automatic test_tx();
        do_clear();
        tx_tkeep = '1; tx_tready = 1; tx_tvalid = 1;
        for (int i = 0; i < 3; i++) begin
            tx_tlast = (i == 2);
            step();
        end
        tx_tlast = 0; tx_tready = 0;
        repeat (2) step();
        tx_tvalid = 0;
        take_snapshot(0);
        checks++;
        if (obs(2) !== 64'd3) begin errors++; $display("FAIL tx_word actual=%0d required=3", obs(2)); end
        checks++;
        if (obs(3) !== 64'd192) begin errors++; $display("FAIL tx_byte actual=%0d required=192", obs(3)); end
        checks++;
        if (obs(4) !== 64'd1) begin errors++; $display("FAIL tx_frame actual=%0d required=1", obs(4)); end
    endtask

    task automatic test_random();
        do_clear();
        for (int n = 0; n < 400; n++) begin
            rand_traffic();
            snapshot = ($urandom_range(0, 9) == 0);
            clear    = ($urandom_range(0, 24) == 0);
            step();
            for (int i = 0; i < NC; i++) begin
                checks++;
                if (obs(i) !== e[i]) begin
                    errors++;
                    $display("FAIL random_%s cycle=%0d actual=%0d required=%0d", nm(i), n, obs(i), e[i]);
                end
            end
            checks++;
            if (snap_valid !== e_valid) begin
                errors++;
                $display("FAIL random_snap_valid cycle=%0d actual=%b required=%b", n, snap_valid, e_valid);
            end
            checks++;
            if (status_ok !== m_sok) begin
                errors++;
                $display("FAIL random_status_ok cycle=%0d actual=%b required=%b", n, status_ok, m_sok);
            end
        end
        quiet();
        for (int n = 0; n < 8 && busy_left != 0; n++) step();
    endtask

    task automatic test_snap_clear();
        do_clear();
        rx_tkeep = '1; rx_tvalid = 1;
        repeat (4) step();
        rx_tvalid = 0;
        snapshot = 1; clear = 1;
        step();                     // now in N+1
        snapshot = 0; clear = 0;
        step();                     // now in N+2
        checks++;
        if (obs(5) !== 64'd4) begin errors++; $display("FAIL snapclr_rx_word actual=%0d required=4", obs(5)); end
        checks++;
        if (snap_valid !== 1'b1) begin errors++; $display("FAIL snapclr_valid_n2 actual=%b required=1", snap_valid); end
        step();                     // now in N+3
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL snapclr_valid_n3 actual=%b required=0", snap_valid); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (obs(i) !== 64'd0) begin
                errors++;
                $display("FAIL snapclr_zero_%s actual=%0d required=0", nm(i), obs(i));
            end
        end
        // commands during SNAP_WAIT are ignored: the clear below must not act
        rand_traffic();
        step();
        snapshot = 1;
        step();
        snapshot = 0; clear = 1;
        step();
        clear = 0;
        quiet();
        step();
        step();
        checks++;
        if (snap_valid !== 1'b1) begin errors++; $display("FAIL ignore_clear_valid actual=%b required=1", snap_valid); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (obs(i) !== e[i]) begin
                errors++;
                $display("FAIL ignore_clear_%s actual=%0d required=%0d", nm(i), obs(i), e[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (5) begin rand_traffic(); step(); end
        take_snapshot(0);
        repeat (3) begin rand_traffic(); step(); end
        #2;
        rst_n = 0;
        #1;
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (obs(i) !== 64'd0) begin
                errors++;
                $display("FAIL async_reset_%s actual=%0d required=0", nm(i), obs(i));
            end
        end
        checks++;
        if (snap_valid !== 1'b0) begin errors++; $display("FAIL async_reset_snap_valid actual=%b required=0", snap_valid); end
        checks++;
        if (status_ok !== 1'b0) begin errors++; $display("FAIL async_reset_status_ok actual=%b required=0", status_ok); end
        model_reset();
        quiet();
        fifo_almost_full = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (6) begin rand_traffic(); step(); end
        take_snapshot(0);
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (obs(i) !== e[i]) begin
                errors++;
                $display("FAIL post_reset_%s actual=%0d required=%0d", nm(i), obs(i), e[i]);
            end
        end
        quiet();
    endtask

    task automatic test_saturation();
        s_rxk = 8'hFF; s_rxl = 1; s_rxv = 1;
        repeat (65534) @(posedge clk);
        #1;
        s_rxv = 0; s_snapshot = 1;
        @(posedge clk); #1;
        s_snapshot = 0;
        @(posedge clk); #1;
        checks++;
        if (s_rxw !== 16'hFFFE) begin errors++; $display("FAIL sat16_rx_word_below actual=%h required=fffe", s_rxw); end
        checks++;
        if (s_rxb !== 16'hFFFF) begin errors++; $display("FAIL sat16_rx_byte actual=%h required=ffff", s_rxb); end
        s_rxv = 1;
        repeat (70000 - 65534) @(posedge clk);
        #1;
        s_rxv = 0; s_snapshot = 1;
        @(posedge clk); #1;
        s_snapshot = 0;
        @(posedge clk); #1;
        checks++;
        if (s_rxw !== 16'hFFFF) begin errors++; $display("FAIL sat16_rx_word actual=%h required=ffff", s_rxw); end
        checks++;
        if (s_rxf !== 16'hFFFF) begin errors++; $display("FAIL sat16_rx_frame actual=%h required=ffff", s_rxf); end
        checks++;
        if (s_snap_valid !== 1'b1) begin errors++; $display("FAIL sat16_snap_valid actual=%b required=1", s_snap_valid); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fifo();
        test_status();
        test_tx();
        test_random();
        test_snap_clear();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aurora_hls_stats.md
AURORA_HLS_STATS -- requirements
Module: aurora_hls_stats

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: AXI-Stream data width in bits, a multiple of 8 in 64..1024.
REQ-002 SHALL have parameter NUM_FIFOS, default 2: number of monitored almost-full flags, 1..8.
REQ-003 SHALL have parameter CNT_WIDTH, default 32: width of every counter, 16..64.
REQ-004 SHALL have parameter STATUS_OK, default 13'h11ff: Aurora core status value that means healthy.
REQ-005 SHALL have clk, input, 1: sole clock; all logic is on its rising edge.
REQ-006 SHALL have rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have aurora_status, input, 13: Aurora core status vector.
REQ-008 SHALL have fifo_almost_full, input, NUM_FIFOS: per-FIFO almost-full flags.
REQ-009 SHALL have tx_tvalid, tx_tready and tx_tlast, inputs, 1 each; and tx_tkeep, input, DATA_WIDTH/8.
REQ-010 SHALL have rx_tvalid and rx_tlast, inputs, 1 each; and rx_tkeep, input, DATA_WIDTH/8. The RX side has no ready signal.
REQ-011 SHALL have clear and snapshot, inputs, 1 each: single-cycle command pulses.
REQ-012 SHALL have status_ok, output, 1: registered flag, high when aurora_status equals STATUS_OK.
REQ-013 SHALL have snap_valid, output, 1: high from the first completed snapshot until the next clear.
REQ-014 SHALL have the following CNT_WIDTH snapshot outputs: status_not_ok_count, link_drop_count, tx_word_count, tx_byte_count, tx_frame_count, rx_word_count, rx_byte_count and rx_frame_count. It SHALL also have fifo_full_count, NUM_FIFOS*CNT_WIDTH, with channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-015 Live counters SHALL saturate at all-ones and SHALL never wrap.
REQ-016 status_not_ok_count SHALL increment on every cycle in which aurora_status != STATUS_OK.
REQ-017 link_drop_count SHALL increment on each 1->0 transition of the registered status_ok.
REQ-018 fifo_full_count[i] SHALL increment once per 0->1 edge of fifo_almost_full[i]. Each channel SHALL have its own previous-value flag.
REQ-019 A TX beat is tx_tvalid && tx_tready. Each TX beat SHALL increment tx_word_count, SHALL add popcount(tx_tkeep) to tx_byte_count, and SHALL increment tx_frame_count if tx_tlast is set.
REQ-020 An RX beat is rx_tvalid. RX beats SHALL update the RX counters under the same rules as REQ-019.
REQ-021 Byte accumulation SHALL be pipelined: popcount is registered in cycle N and added in cycle N+1. All other events SHALL be counted in cycle N+1 after the input cycle.
REQ-022 Outputs SHALL be shadow registers, not the live counters. A snapshot pulse in cycle N SHALL load all shadows from the live values in cycle N+2, so that in-flight byte sums are included. snap_valid SHALL rise in the same cycle as the shadow load.
REQ-023 Control FSM states SHALL be IDLE, SNAP_WAIT (1 cycle) and CLEAR (1 cycle).
- IDLE -> SNAP_WAIT on snapshot.
- IDLE -> CLEAR on clear.
- SNAP_WAIT -> IDLE after the shadow load.
- CLEAR -> IDLE.
REQ-024 In CLEAR, all live counters, the byte pipeline, the shadows and snap_valid SHALL go to 0. Events arriving during the CLEAR cycle SHALL be dropped.
REQ-025 If snapshot and clear arrive in the same cycle, the snapshot SHALL be taken first (pre-clear values) and CLEAR SHALL follow immediately after SNAP_WAIT.
REQ-026 Command pulses arriving outside IDLE SHALL be ignored, except for the queued clear defined in REQ-025.
REQ-027 Saturation SHALL be applied after the add: a byte add that would exceed the maximum SHALL yield all-ones.

Reset
REQ-028 While rst_n is low, the following SHALL be 0: all counters, shadows, the pipeline, snap_valid and status_ok. The FSM SHALL be in IDLE.
REQ-029 While rst_n is low, the per-FIFO previous flags SHALL be 1, so a FIFO that is already almost-full at reset release is not counted.
REQ-030 Reset assertion SHALL be asynchronous. Reset release SHALL be honoured on the next clk edge. A reset mid-snapshot SHALL abort it.

Structure
REQ-031 A shared package aurora_hls_pkg SHALL hold the STATUS_OK default, the FSM state encoding and the default CNT_WIDTH.
REQ-032 A sub-module aurora_hls_sat_counter SHALL provide a parametrised saturating accumulator with clear, increment-value and enable inputs. It SHALL be instantiated once per counter.

Verification
REQ-033 Scenario: aurora_status=13'h11ff for 10 cycles, then 13'h0000 for 5 cycles, then snapshot. Required: status_not_ok_count=5, link_drop_count=1.
REQ-034 Scenario: 3 TX beats with tkeep all-ones (DATA_WIDTH=512), the last beat with tlast, plus 2 cycles with tvalid=1 and tready=0, then snapshot. Required: tx_word=3, tx_byte=192, tx_frame=1.
REQ-035 Scenario: fifo_almost_full[1] toggles 0->1->0->1, and fifo_almost_full[0] is held at 1 through reset release. Required: fifo_full_count ch1=2, ch0=0.
REQ-036 Scenario: CNT_WIDTH=16, 70000 RX beats. Required: rx_word_count=16'hFFFF.
REQ-037 Scenario: snapshot and clear in the same cycle, after 4 RX beats. Required: shadow rx_word=4 and snap_valid=1 in cycle N+2; then at N+3 the shadows are 0 and snap_valid=0.
REQ-038 Scenario: rst_n pulsed low mid-traffic, without any clock edge. Required: all outputs read 0 immediately.
